// File: rtl/dm_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dm_responder_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = 4;

  logic            req_valid;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [BEW-1:0]  req_be;
  logic [XLEN-1:0] req_pc;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_stall
  );
endinterface

// File: rtl/dm_responder.sv
// Wait-stated data-memory responder for the MEM stage; stalls the requester until the response.
// Define DM_ALIGN_CHECK_EN to flag misaligned byte-enable/address pairs through resp_err.
module dm_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  dm_responder_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 4;
  localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q;
  logic [XLEN-1:0]   addr_q, wdata_q, pc_q;
  logic [3:0]        be_q;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

  logic              accept, enter_resp;
  logic              acc_we;
  logic [XLEN-1:0]   acc_addr, acc_wdata, acc_pc;
  logic [3:0]        acc_be;
  logic [29:0]       widx;
  logic              in_range;
  logic [AW-1:0]     midx;
  logic [XLEN-1:0]   old_word, merged;
  logic              acc_err;
  logic              do_store;

  assign accept     = (state_q == IDLE) && bus.req_valid && ready_q;
  assign enter_resp = (state_d == RESP);

  // With zero wait states the access happens on the accept edge, before the latch is loaded.
  assign acc_we    = (state_q == IDLE) ? bus.req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign acc_be    = (state_q == IDLE) ? bus.req_be    : be_q;
  assign acc_pc    = (state_q == IDLE) ? bus.req_pc    : pc_q;

  assign widx     = 30'((acc_addr - ADDR_BASE) >> 2);
  assign in_range = ({2'b00, widx} < 32'(DEPTH_WORDS));
  assign midx     = AW'(widx);
  assign old_word = in_range ? mem_q[midx] : '0;

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (acc_be[i]) merged[8*i +: 8] = acc_wdata[8*i +: 8];
    end
  end

`ifdef DM_ALIGN_CHECK_EN
  // Only naturally aligned word, halfword and byte lanes are legal.
  always_comb begin
    acc_err = 1'b1;
    unique case (acc_be)
      4'b0000:                   acc_err = 1'b0;
      4'b1111, 4'b0011, 4'b0001: acc_err = (acc_addr[1:0] != 2'd0);
      4'b1100, 4'b0100:          acc_err = (acc_addr[1:0] != 2'd2);
      4'b0010:                   acc_err = (acc_addr[1:0] != 2'd1);
      4'b1000:                   acc_err = (acc_addr[1:0] != 2'd3);
      default:                   acc_err = 1'b1;
    endcase
  end
`else
  assign acc_err = 1'b0;
`endif

  assign do_store      = enter_resp && acc_we && in_range && !acc_err;
  assign bus.mem_stall = bus.req_valid & ~valid_q;
  assign bus.req_ready = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == CW'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and counter next values, registered below
  always_comb begin
    ready_d = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    cnt_d   = cnt_q;
    if (accept)                cnt_d = CW'(WAIT_CYCLES);
    else if (state_q == WAIT)  cnt_d = cnt_q - CW'(1);
    if (state_d == IDLE) ready_d = 1'b1;
    if (enter_resp) begin
      valid_d = 1'b1;
      err_d   = acc_err;
      if (!acc_we && !acc_err) rdata_d = old_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      pc_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
        pc_q    <= bus.req_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[AW'(i)] <= '0;
    end else if (do_store) begin
      mem_q[midx] <= merged;
    end
  end

`ifndef SYNTHESIS
  // Store trace for comparison against the reference ISS.
  always @(posedge clk) begin
    if (!reset && do_store)
      $display("@%h: *%h <= %h", acc_pc, {acc_addr[31:2], 2'b00}, merged);
  end
`endif
endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: a 2-wait-state and a 0-wait-state instance.
module tb_dm_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_responder_if bus0 ();
  dm_responder_if bus1 ();

  dm_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(3072), .ADDR_BASE(32'h0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  dm_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(3072), .ADDR_BASE(32'h0)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [32:0] sb0 [$];
  logic [32:0] sb1 [$];

`ifdef DM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ready_of(input bit s);
    return s ? bus1.req_ready : bus0.req_ready;
  endfunction
  function automatic logic valid_of(input bit s);
    return s ? bus1.resp_valid : bus0.resp_valid;
  endfunction
  function automatic logic stall_of(input bit s);
    return s ? bus1.mem_stall : bus0.mem_stall;
  endfunction

  task automatic drive(input bit s, input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (s) begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = addr;
      bus1.req_wdata = wdata; bus1.req_be = be; bus1.req_pc = 32'h1000 + addr;
    end else begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = addr;
      bus0.req_wdata = wdata; bus0.req_be = be; bus0.req_pc = 32'h1000 + addr;
    end
  endtask

  // Issue one request, push its expected response, check latency, stall length and re-arm.
  task automatic issue(input bit s, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                       input int wc, input string tag);
    int  stall = 0;
    int  lat   = 0;
    int  guard = 0;
    bit  acc   = 1'b0;
    bit  rv    = 1'b0;
    if (s) sb1.push_back({exp_err, exp_rdata});
    else   sb0.push_back({exp_err, exp_rdata});
    drive(s, 1'b1, we, addr, wdata, be);
    while (!acc && guard < 50) begin
      @(negedge clk);
      if (stall_of(s)) stall++;
      acc = ready_of(s);
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) chk({tag, " accept"}, 32'(acc), 32'd1);
    while (!rv && lat < 50) begin
      @(negedge clk);
      lat++;
      rv = valid_of(s);
      if (stall_of(s)) stall++;
      if (rv) chk({tag, " ready during resp"}, 32'(ready_of(s)), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(wc + 1));
    chk({tag, " stall cycles"}, 32'(stall), 32'(wc + 1));
    drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk({tag, " ready after resp"}, 32'(ready_of(s)), 32'd1);
    @(posedge clk); #1;
  endtask

  // Response monitors: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && bus0.resp_valid === 1'b1) begin
      if (sb0.size() == 0) chk("dut0 unexpected resp", 32'(bus0.resp_valid), 32'd0);
      else begin
        e = sb0.pop_front();
        chk("dut0 rdata", bus0.resp_rdata, e[31:0]);
        chk("dut0 err", 32'(bus0.resp_err), 32'(e[32]));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && bus1.resp_valid === 1'b1) begin
      if (sb1.size() == 0) chk("dut1 unexpected resp", 32'(bus1.resp_valid), 32'd0);
      else begin
        e = sb1.pop_front();
        chk("dut1 rdata", bus1.resp_rdata, e[31:0]);
        chk("dut1 err", 32'(bus1.resp_err), 32'(e[32]));
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(bus0.req_ready), 32'd1);
    chk("reset resp_valid", 32'(bus0.resp_valid), 32'd0);
    chk("reset rdata", bus0.resp_rdata, 32'd0);
    chk("reset err", 32'(bus0.resp_err), 32'd0);
    chk("reset stall", 32'(bus0.mem_stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic store then load
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 2, "t1 sw");
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0, 2, "t1 lw");

    // Byte-lane merges and an empty-enable store
    issue(1'b0, 1'b1, 32'h22, 32'h00AB0000, 4'b0100, 32'h0, 1'b0, 2, "t2 sw b2");
    issue(1'b0, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h00AB0000, 1'b0, 2, "t2 lw");
    issue(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 2, "t2 sw be0");
    issue(1'b0, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h00AB0000, 1'b0, 2, "t2 lw be0");
    issue(1'b0, 1'b1, 32'h20, 32'h111111CD, 4'b0001, 32'h0, 1'b0, 2, "t2 sw b0");
    issue(1'b0, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h00AB00CD, 1'b0, 2, "t2 lw b0");

    // Range boundary: last word works, first word past the end is dropped
    issue(1'b0, 1'b1, 32'h2FFC, 32'hA5A5A5A5, 4'b1111, 32'h0, 1'b0, 2, "t3 sw last");
    issue(1'b0, 1'b0, 32'h2FFC, 32'h0, 4'b1111, 32'hA5A5A5A5, 1'b0, 2, "t3 lw last");
    issue(1'b0, 1'b1, 32'h3000, 32'h12345678, 4'b1111, 32'h0, 1'b0, 2, "t3 sw oor");
    issue(1'b0, 1'b0, 32'h3000, 32'h0, 4'b1111, 32'h0, 1'b0, 2, "t3 lw oor");

    // Reset one cycle after a store is accepted
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h11111111, 4'b1111);
    guard = 0;
    while (bus0.req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("t4 accept", 32'(bus0.req_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t4 ready after reset", 32'(bus0.req_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    issue(1'b0, 1'b0, 32'h40, 32'h0, 4'b1111, 32'h0, 1'b0, 2, "t4 lw");
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h0, 1'b0, 2, "t4 lw cleared");

    // Misaligned word store
    issue(1'b0, 1'b1, 32'h12, 32'hCAFEF00D, 4'b1111, 32'h0, ALIGN, 2, "t6 sw");
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'b1111, ALIGN ? 32'h0 : 32'hCAFEF00D, 1'b0, 2, "t6 lw");

    // Zero wait states
    issue(1'b1, 1'b0, 32'h8, 32'h0, 4'b1111, 32'h0, 1'b0, 0, "t5 lw0");
    issue(1'b1, 1'b1, 32'h8, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, 0, "t5 sw");
    issue(1'b1, 1'b0, 32'h8, 32'h0, 4'b1111, 32'h0BADF00D, 1'b0, 0, "t5 lw");

    repeat (4) @(posedge clk);
    #1;
    chk("sb0 drained", 32'(sb0.size()), 32'd0);
    chk("sb1 drained", 32'(sb1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
